// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding types: opcode constants, instruction formats and the
// encoder FIFO entry payload.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_SYSTEM = 7'b1110011,
    OPC_FENCE  = 7'b0001111,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_OP     = 7'b0110011
  } rv_opcode_t;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } inst_fmt_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic            err;
  } enc_entry_t;

  // Instruction format implied by an opcode; unknown opcodes map to FMT_BAD.
  function automatic inst_fmt_t fmt_of(input logic [6:0] opcode);
    inst_fmt_t fmt;
    fmt = FMT_BAD;
    case (opcode)
      OPC_LUI, OPC_AUIPC:                                    fmt = FMT_U;
      OPC_JAL:                                               fmt = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM, OPC_FENCE: fmt = FMT_I;
      OPC_STORE:                                             fmt = FMT_S;
      OPC_BRANCH:                                            fmt = FMT_B;
      OPC_OP:                                                fmt = FMT_R;
      default:                                               fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/inst_field_pack.sv
// Combinational packer: rebuilds a 32-bit RV32I word from decoded fields and
// flags fields that the selected format cannot represent.
module inst_field_pack
  import rv32i_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd_s,
  input  logic [4:0]  rs1_s,
  input  logic [4:0]  rs2_s,
  input  logic [31:0] imm,
  output enc_entry_t  entry_c
);

  inst_fmt_t fmt;
  logic      is_shift;
  logic      i_fits;
  logic      b_fits;
  logic      j_fits;

  assign fmt      = fmt_of(opcode);
  // funct3 001/101 under OP-IMM are the shift-immediate forms
  assign is_shift = (opcode == OPC_OP_IMM) && (funct3[1:0] == 2'b01);

  // Upper immediate bits must be pure sign extension of the encodable field
  assign i_fits = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_fits = (&imm[31:12]) | ~(|imm[31:12]);
  assign j_fits = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    entry_c.inst = '0;
    entry_c.err  = 1'b0;
    case (fmt)
      FMT_R: begin
        entry_c.inst = {funct7, rs2_s, rs1_s, funct3, rd_s, opcode};
      end
      FMT_I: begin
        if (is_shift) begin
          entry_c.inst = {funct7, imm[4:0], rs1_s, funct3, rd_s, opcode};
          entry_c.err  = |imm[31:5];
        end else begin
          entry_c.inst = {imm[11:0], rs1_s, funct3, rd_s, opcode};
          entry_c.err  = ~i_fits;
        end
      end
      FMT_S: begin
        entry_c.inst = {imm[11:5], rs2_s, rs1_s, funct3, imm[4:0], opcode};
        entry_c.err  = ~i_fits;
      end
      FMT_B: begin
        entry_c.inst = {imm[12], imm[10:5], rs2_s, rs1_s, funct3,
                        imm[4:1], imm[11], opcode};
        entry_c.err  = ~b_fits | imm[0];
      end
      FMT_U: begin
        entry_c.inst = {imm[31:12], rd_s, opcode};
        entry_c.err  = |imm[11:0];
      end
      FMT_J: begin
        entry_c.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd_s, opcode};
        entry_c.err  = ~j_fits | imm[0];
      end
      default: begin
        entry_c.inst = {25'b0, opcode};
        entry_c.err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder with output FIFO: packs accepted field bundles and
// queues the encoded words for the trace / round-trip consumers.
module inst_encoder
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [6:0]             in_opcode,
  input  logic [2:0]             in_funct3,
  input  logic [6:0]             in_funct7,
  input  logic [4:0]             in_rd_s,
  input  logic [4:0]             in_rs1_s,
  input  logic [4:0]             in_rs2_s,
  input  logic [31:0]            in_imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("inst_encoder: DEPTH must be a power of two and at least 2");
  end

  enc_entry_t        pack_c;
  enc_entry_t        mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              push;
  logic              pop;

  inst_field_pack u_pack (
    .opcode  (in_opcode),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .rd_s    (in_rd_s),
    .rs1_s   (in_rs1_s),
    .rs2_s   (in_rs2_s),
    .imm     (in_imm),
    .entry_c (pack_c)
  );

  // Ready/valid are decodes of the registered occupancy only; no lookahead
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage is cleared on reset so the head reads as zero while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= pack_c;
        wptr      <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_inst = mem[rptr].inst;
  assign out_err  = mem[rptr].err;

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder and output buffer: accepts decoded RV32I fields (opcode, funct3, funct7, register indices, sign-extended immediate) over a valid/ready handshake, packs them back into a 32-bit instruction word in the format the opcode implies, and queues the result in a small FIFO. It feeds the commit-trace / RVFI instruction-word path and the decode round-trip checker. Re-decoding its output must reproduce the input fields exactly; any field that cannot be represented is flagged.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥ 2

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle this cycle
- in_opcode  input  7  opcode
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7; used for R-type and shift-immediate
- in_rd_s / in_rs1_s / in_rs2_s  input  5 each  register indices
- in_imm  input  32  sign-extended immediate as produced by decode
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head entry
- out_inst  output  32  encoded instruction word
- out_err  output  1  head entry has an unrepresentable field or unknown opcode
- count  output  $clog2(DEPTH)+1  occupied entries

## Operation
- Format select by opcode:
  - U: 0110111, 0010111
  - J: 1101111
  - I: 1100111, 0000011, 0010011, 1110011, 0001111
  - S: 0100011
  - B: 1100011
  - R: 0110011
  - anything else: word = {25'b0, opcode}, err=1
- Packing, inverse of decode:
  - I: inst[31:20]=imm[11:0]
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]
  - B: inst[31]=imm[12], inst[7]=imm[11], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1]
  - U: inst[31:12]=imm[31:12]
  - J: inst[31]=imm[20], inst[19:12]=imm[19:12], inst[20]=imm[11], inst[30:21]=imm[10:1]
  - rd/rs1/rs2/funct3/funct7 go to their standard slots only where the format has them; unused slots are 0.
- Shift-immediate (0010011, funct3 001/101): inst[31:25]=funct7, inst[24:20]=imm[4:0].
- err=1 if:
  - I/S: imm[31:11] is not all-equal
  - B: imm[31:12] is not all-equal, or imm[0]=1
  - J: imm[31:20] is not all-equal, or imm[0]=1
  - U: imm[11:0]≠0
  - shift: imm[31:5]≠0
- An erroneous word is still encoded with truncated fields and is still enqueued.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count < DEPTH); it does not look ahead on same-cycle pop.
- out_valid = (count ≠ 0).
- Push and pop in the same cycle (non-empty, non-full): count unchanged, order preserved.
- Read and write pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous, immediate): count=0, pointers=0, out_valid=0, in_ready=1, out_inst=0, out_err=0. Data contents are don't-care.
- Reset mid-operation discards all queued entries. First push after rst deasserts is accepted on the next rising edge.
- Latency: a bundle pushed at edge N appears on out_inst/out_err with out_valid=1 after edge N. There is no combinational in→out path.
- out_inst/out_err are driven from the head entry. They hold stable while out_valid && !out_ready.
- in_valid while !in_ready: no state change; the producer holds the bundle.
- Full: a same-cycle pop does not allow a push; in_ready returns 1 the cycle after the pop.
- Empty: out_ready is ignored.

## Structure
- Shared package `rv32i_pkg`:
  - opcode constants enum `rv_opcode_t`
  - format enum `inst_fmt_t` {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD}
  - struct `enc_entry_t` {logic [31:0] inst; logic err;}
- Sub-module `inst_field_pack`: purely combinational format select, packing and error check. The top holds only the FIFO and handshake logic.

## Test plan
- ADDI x1,x0,5 (opcode 0010011, f3 000, rd 1, rs1 0, imm 5) → out_inst=0x00500093, err=0, out_valid one cycle after push.
- LUI x5 imm 0x12345000 → 0x123452B7, err=0. Same with imm 0x12345001 → 0x123452B7, err=1.
- BEQ x1,x2 imm 0xFFFFFFFC → 0xFE208EE3, err=0. JAL x1 imm 0x00000003 → err=1.
- Push 4 bundles with out_ready=0: count=4, in_ready=0, and a 5th push is held. Pop one with the 5th still asserted: 5th accepted the next cycle. Drain: order is preserved.
- Continuous push+pop at count=2 for 10 cycles across a pointer wrap: count stays 2, no loss or duplication.
- Assert rst with count=3 mid-stream: out_valid drops immediately, count=0. The next word is the first one pushed after reset.
- Random round-trip: legal random fields → re-decode of out_inst reproduces every format-relevant field, err=0.
